// File: rtl/uart_frame_sender_if.sv
// Byte handshake between the frame sender and the UART byte transmitter.
// The sender drives data_byte/send_en; the transmitter answers with tx_done.
interface uart_frame_sender_if;
  logic [7:0] data_byte;
  logic       send_en;
  logic       tx_done;

  modport master (
    output data_byte,
    output send_en,
    input  tx_done
  );

  modport slave (
    input  data_byte,
    input  send_en,
    output tx_done
  );
endinterface

// File: rtl/uart_frame_sender.sv
// Frames queued payload bytes as HEADER, LEN, payload, CSUM and feeds them one
// at a time to the UART byte transmitter through a send_en/tx_done handshake.
module uart_frame_sender #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter logic [7:0]  HEADER = 8'hAA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              fifo_full,
  output logic [ADDR_W:0]   fifo_count,
  output logic              wr_overflow,
  input  logic              frame_start,
  output logic              busy,
  output logic              frame_done,
  uart_frame_sender_if.master tx
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR_SEND,
    S_HDR_WAIT,
    S_LEN_SEND,
    S_LEN_WAIT,
    S_PAY_SEND,
    S_PAY_WAIT,
    S_CSUM_SEND,
    S_CSUM_WAIT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  // Payload FIFO
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic              overflow_q;
  logic              overflow_d;
  logic              push;
  logic              pop;
  logic [7:0]        head;

  // Frame FSM
  state_t            state_q;
  logic [ADDR_W:0]   remain_q;
  logic [7:0]        csum_q;
  logic [7:0]        data_q;
  logic              send_q;
  logic              busy_q;
  logic              done_q;

  assign head = mem_q[rd_ptr_q];

  // The payload byte leaves the FIFO in the cycle its strobe is on the wire.
  assign pop = (state_q == S_PAY_SEND);

  // A full FIFO still takes a write when a pop frees a slot in the same cycle.
  assign push       = wr_en && ((count_q != FULL_CNT) || pop);
  assign overflow_d = wr_en && (count_q == FULL_CNT) && !pop;
  assign count_d    = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      remain_q <= '0;
      csum_q   <= '0;
      data_q   <= '0;
      send_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      send_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        // DONE behaves like IDLE so a new frame can start right after frame_done.
        S_IDLE, S_DONE: begin
          if (frame_start) begin
            state_q  <= S_HDR_SEND;
            remain_q <= count_q;
            csum_q   <= 8'(count_q);
            data_q   <= HEADER;
            send_q   <= 1'b1;
            busy_q   <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_HDR_SEND: state_q <= S_HDR_WAIT;
        S_HDR_WAIT: begin
          if (tx.tx_done) begin
            state_q <= S_LEN_SEND;
            data_q  <= 8'(remain_q);
            send_q  <= 1'b1;
          end
        end
        S_LEN_SEND: state_q <= S_LEN_WAIT;
        S_PAY_SEND: state_q <= S_PAY_WAIT;
        // remain_q counts payload bytes still to go; LEN and payload share the exit.
        S_LEN_WAIT, S_PAY_WAIT: begin
          if (tx.tx_done) begin
            send_q <= 1'b1;
            if (remain_q != '0) begin
              state_q  <= S_PAY_SEND;
              data_q   <= head;
              csum_q   <= csum_q + head;
              remain_q <= remain_q - (ADDR_W+1)'(1);
            end else begin
              state_q <= S_CSUM_SEND;
              data_q  <= csum_q;
            end
          end
        end
        S_CSUM_SEND: state_q <= S_CSUM_WAIT;
        S_CSUM_WAIT: begin
          if (tx.tx_done) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fifo_full    = (count_q == FULL_CNT);
  assign fifo_count   = count_q;
  assign wr_overflow  = overflow_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign tx.data_byte = data_q;
  assign tx.send_en   = send_q;

endmodule

// File: tb/tb_uart_frame_sender.sv
// Bench for uart_frame_sender: a queue-based frame model checked every cycle,
// directed frames with literal expectations, then randomized traffic.
module tb_uart_frame_sender;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam logic [7:0]  HDR    = 8'hAA;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              fifo_full;
  logic [ADDR_W:0]   fifo_count;
  logic              wr_overflow;
  logic              frame_start;
  logic              busy;
  logic              frame_done;

  uart_frame_sender_if tx_if ();

  uart_frame_sender #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HEADER(HDR)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .fifo_full(fifo_full), .fifo_count(fifo_count), .wr_overflow(wr_overflow),
    .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
    .tx(tx_if.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  bit          m_valid = 1'b0;
  bit          m_busy, m_done, m_send, m_ovf, m_wait;
  logic [7:0]  m_data;
  logic [7:0]  q_fifo[$];
  logic [7:0]  m_frame[$];
  int          m_idx, m_len;
  bit          pop_now, old_wait, old_busy, n_send, n_done, n_ovf;
  int          sz;
  logic [7:0]  s, tmp;

  int          cyc = 0;
  logic [7:0]  slog[$];
  int          scyc[$];
  int          done_cnt = 0;
  int          ovf_cnt = 0;
  int          dcyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (tx_if.send_en === 1'b1) begin
      slog.push_back(tx_if.data_byte);
      scyc.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      dcyc = cyc;
    end
    if (wr_overflow === 1'b1) ovf_cnt++;

    if (m_valid) begin
      chk("send_en", 32'(tx_if.send_en), 32'(m_send));
      chk("data_byte", 32'(tx_if.data_byte), 32'(m_data));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("frame_done", 32'(frame_done), 32'(m_done));
      chk("fifo_count", 32'(fifo_count), 32'(q_fifo.size()));
      chk("fifo_full", 32'(fifo_full), 32'(q_fifo.size() == DEPTH));
      chk("wr_overflow", 32'(wr_overflow), 32'(m_ovf));
    end

    if (rst === 1'b1) begin
      m_valid = 1'b1;
      m_busy = 0; m_done = 0; m_send = 0; m_ovf = 0; m_wait = 0;
      m_data = 8'h00;
      q_fifo.delete();
      m_frame.delete();
      m_idx = 0; m_len = 0;
    end else if (m_valid) begin
      pop_now  = m_send && (m_idx >= 2) && (m_idx < 2 + m_len);
      old_wait = m_wait;
      old_busy = m_busy;
      n_send = 0; n_done = 0;
      if (m_send) begin
        m_wait = 1;
        m_idx++;
      end else if (old_wait && tx_if.tx_done) begin
        m_wait = 0;
        if (m_idx < m_frame.size()) begin
          n_send = 1;
          m_data = m_frame[m_idx];
        end else begin
          n_done = 1;
          m_busy = 0;
        end
      end
      if (!old_busy && frame_start) begin
        m_len = q_fifo.size();
        m_frame.delete();
        m_frame.push_back(HDR);
        m_frame.push_back(8'(m_len));
        s = 8'(m_len);
        for (int i = 0; i < m_len; i++) begin
          m_frame.push_back(q_fifo[i]);
          s = s + q_fifo[i];
        end
        m_frame.push_back(s);
        m_idx = 0; m_wait = 0;
        n_send = 1; m_data = HDR; m_busy = 1;
      end
      sz    = q_fifo.size();
      n_ovf = wr_en && (sz == DEPTH) && !pop_now;
      if (pop_now) tmp = q_fifo.pop_front();
      if (wr_en && ((sz < DEPTH) || pop_now)) q_fifo.push_back(wr_data);
      m_send = n_send;
      m_done = n_done;
      m_ovf  = n_ovf;
    end
  end

  // ---------------- stimulus with transmitter responder ----------------
  int tx_cnt   = 0;
  int tx_delay = 20;
  bit spur_en  = 1'b0;

  task automatic tick(input logic we, input logic [7:0] wd, input logic fs, input logic r);
    @(posedge clk);
    #1;
    if (tx_cnt > 0) begin
      tx_cnt--;
      tx_if.tx_done = (tx_cnt == 0);
    end else begin
      tx_if.tx_done = spur_en && (busy === 1'b0) && ($urandom_range(0, 7) == 0);
    end
    if (tx_if.send_en === 1'b1)
      tx_cnt = (tx_delay > 0) ? tx_delay : int'($urandom_range(1, 6));
    wr_en = we; wr_data = wd; frame_start = fs; rst = r;
  endtask

  task automatic wait_done(input int budget, input string name);
    int base_d = done_cnt;
    int n = 0;
    while (done_cnt == base_d && n < budget) begin
      tick(0, 8'h00, 0, 0);
      n++;
    end
    if (done_cnt == base_d) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no frame_done within %0d cycles, expected one", name, budget);
    end
  endtask

  int base, dbase, ob, n;
  logic [7:0] exp6 [6] = '{8'hAA, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};

  initial begin
    rst = 1'b1; wr_en = 0; wr_data = 0; frame_start = 0;
    tx_if.tx_done = 1'b0;
    tick(0, 8'h00, 0, 1);
    tick(0, 8'h00, 0, 1);
    tick(0, 8'h00, 0, 0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_send_en", 32'(tx_if.send_en), 32'd0);
    chk("rst_data_byte", 32'(tx_if.data_byte), 32'h00);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);

    // 3-byte frame, transmitter answers 20 cycles after each strobe
    base = slog.size();
    tick(1, 8'h01, 0, 0);
    tick(1, 8'h02, 0, 0);
    tick(1, 8'h03, 0, 0);
    tick(0, 8'h00, 1, 0);
    wait_done(400, "t3_done");
    chk("t3_nbytes", 32'(slog.size() - base), 32'd6);
    if (slog.size() - base >= 6) begin
      for (int k = 0; k < 6; k++) chk("t3_byte", 32'(slog[base+k]), 32'(exp6[k]));
      for (int k = 1; k < 6; k++) chk("t3_gap", 32'(scyc[base+k] - scyc[base+k-1]), 32'd21);
      chk("t3_done_lat", 32'(dcyc - scyc[base+5]), 32'd21);
    end
    chk("t3_fifo_count", 32'(fifo_count), 32'd0);

    // empty frame
    base = slog.size(); dbase = done_cnt;
    tick(0, 8'h00, 1, 0);
    wait_done(200, "t0_done");
    repeat (5) tick(0, 8'h00, 0, 0);
    chk("t0_nbytes", 32'(slog.size() - base), 32'd3);
    if (slog.size() - base >= 3) begin
      chk("t0_hdr", 32'(slog[base]), 32'hAA);
      chk("t0_len", 32'(slog[base+1]), 32'h00);
      chk("t0_csum", 32'(slog[base+2]), 32'h00);
    end
    chk("t0_done_pulses", 32'(done_cnt - dbase), 32'd1);

    // full FIFO plus one dropped write, checksum wraps to 00
    ob = ovf_cnt;
    repeat (17) tick(1, 8'hFF, 0, 0);
    tick(0, 8'h00, 0, 0);
    tick(0, 8'h00, 0, 0);
    chk("full_flag", 32'(fifo_full), 32'd1);
    chk("full_count", 32'(fifo_count), 32'd16);
    chk("full_ovf_pulses", 32'(ovf_cnt - ob), 32'd1);
    base = slog.size();
    tick(0, 8'h00, 1, 0);
    wait_done(1000, "full_done");
    chk("full_nbytes", 32'(slog.size() - base), 32'd19);
    if (slog.size() - base >= 19) begin
      chk("full_len", 32'(slog[base+1]), 32'h10);
      for (int k = 2; k < 18; k++) chk("full_pay", 32'(slog[base+k]), 32'hFF);
      chk("full_csum", 32'(slog[base+18]), 32'h00);
    end

    // writes and a second frame_start during a 2-byte frame
    base = slog.size();
    tick(1, 8'h5A, 0, 0);
    tick(1, 8'hA5, 0, 0);
    tick(0, 8'h00, 1, 0);
    tick(1, 8'h11, 0, 0);
    tick(1, 8'h22, 0, 0);
    tick(1, 8'h33, 0, 0);
    repeat (3) tick(0, 8'h00, 0, 0);
    tick(0, 8'h00, 1, 0);
    wait_done(500, "cc_done");
    repeat (5) tick(0, 8'h00, 0, 0);
    chk("cc_nbytes", 32'(slog.size() - base), 32'd5);
    if (slog.size() - base >= 5) begin
      chk("cc_len", 32'(slog[base+1]), 32'h02);
      chk("cc_csum", 32'(slog[base+4]), 32'h01);
    end
    chk("cc_fifo_count", 32'(fifo_count), 32'd3);

    // reset after the second payload strobe
    base = slog.size();
    tick(0, 8'h00, 1, 0);
    n = 0;
    while (slog.size() - base < 4 && n < 300) begin
      tick(0, 8'h00, 0, 0);
      n++;
    end
    if (slog.size() - base < 4) begin
      n_checks++; n_errors++;
      $display("FAIL mr_reach: %0d strobes seen, expected 4", slog.size() - base);
    end
    tick(0, 8'h00, 0, 1);
    tick(0, 8'h00, 0, 1);
    repeat (60) tick(0, 8'h00, 0, 0);
    chk("mr_nbytes", 32'(slog.size() - base), 32'd4);
    chk("mr_fifo_count", 32'(fifo_count), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    base = slog.size();
    tick(1, 8'h07, 0, 0);
    tick(1, 8'h08, 0, 0);
    tick(0, 8'h00, 1, 0);
    wait_done(400, "mr_fresh_done");
    chk("mr_fresh_nbytes", 32'(slog.size() - base), 32'd5);
    if (slog.size() - base >= 5) begin
      chk("mr_fresh_len", 32'(slog[base+1]), 32'h02);
      chk("mr_fresh_p0", 32'(slog[base+2]), 32'h07);
      chk("mr_fresh_csum", 32'(slog[base+4]), 32'h11);
    end

    // randomized traffic: random delays, spurious tx_done while idle, rare resets
    tx_delay = 0;
    spur_en  = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      tick(($urandom_range(0, 9) < 3), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 24) == 0), (i % 2000 == 1999));
    end
    spur_en = 1'b0;
    repeat (20) tick(0, 8'h00, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_sender.md
# uart_frame_sender

Framing stage upstream of the UART byte transmitter. Application logic pushes payload bytes into an internal show-ahead FIFO and pulses `frame_start`. The block then emits one frame, byte by byte, through the transmitter's `data_byte`/`send_en`/`tx_done` handshake: header, length, payload, checksum. The Arduino side uses the header and checksum to resynchronise and reject corrupted OLED updates.

## Interface
- `DEPTH`, default 16: payload FIFO depth; power of two, range 2..128.
- `ADDR_W`, default 4: log2(`DEPTH`).
- `HEADER`, default 8'hAA: first byte of every frame.

- `clk` in 1: system clock.
- `rst` in 1: reset; one clock, synchronous, active-high.
- `wr_en` in 1: push `wr_data` into the FIFO.
- `wr_data` in 8: payload byte.
- `fifo_full` out 1: FIFO holds `DEPTH` bytes.
- `fifo_count` out ADDR_W+1: FIFO occupancy, 0..`DEPTH`.
- `wr_overflow` out 1: 1-cycle pulse when a write is dropped because the FIFO is full.
- `frame_start` in 1: request one frame.
- `busy` out 1: high from the cycle after an accepted `frame_start` until `frame_done`.
- `frame_done` out 1: 1-cycle pulse when the final byte has completed.
- `data_byte` out 8: byte to the transmitter.
- `send_en` out 1: 1-cycle start strobe to the transmitter.
- `tx_done` in 1: 1-cycle completion pulse from the transmitter.

## Operation
- Frame format: `HEADER`, LEN, LEN payload bytes in FIFO order, CSUM.
  - LEN = `fifo_count` sampled in the cycle `frame_start` is accepted; range 0..`DEPTH`.
  - CSUM = (LEN + sum of payload bytes) mod 256, accumulated in an 8-bit register with wrap.
- States:
  - IDLE: accepts `frame_start` → HDR.
  - HDR → LEN.
  - LEN → PAY if LEN > 0, else → CSUM.
  - PAY: repeats until LEN payload bytes have been sent, then → CSUM.
  - CSUM → DONE.
  - DONE → IDLE.
  - Each of HDR/LEN/PAY/CSUM has a send sub-step and a wait sub-step. The send sub-step asserts `send_en` for exactly one cycle with `data_byte` valid; the wait sub-step holds until `tx_done`.
- `data_byte` holds its value from the `send_en` cycle until the next `send_en`.
- FIFO:
  - Show-ahead: the head byte is visible without a read.
  - A payload byte is popped in the same cycle its `send_en` is asserted.
  - Simultaneous push and pop in one cycle is legal and leaves `fifo_count` unchanged.
- Writes during a frame are accepted. They are not counted in the current LEN and remain for the next frame.
- `frame_start` while `busy` is ignored; no queuing.
- A `tx_done` arriving outside a wait sub-step is ignored.
- Write when full:
  - Data is dropped and `wr_overflow` pulses.
  - If a pop occurs in the same cycle, the write is accepted instead and no overflow is flagged.
- Reset mid-frame:
  - FSM returns to IDLE, FIFO is emptied, checksum is cleared.
  - Any in-flight transmitter byte finishes on its own; the resulting `tx_done` is ignored.

## Timing
- Reset values:
  - `busy`, `frame_done`, `send_en`, `wr_overflow`, `fifo_full` = 0.
  - `data_byte` = 8'h00; `fifo_count` = 0.
- `frame_start` sampled high at cycle t while IDLE:
  - `busy` = 1 at t+1.
  - `send_en` = 1 at t+1 with `data_byte` = `HEADER`.
- `tx_done` at cycle d: the next `send_en` is at d+1. The inter-byte gap is therefore entirely transmitter time plus one cycle.
- `tx_done` for CSUM at cycle d:
  - `frame_done` = 1 at d+1.
  - `busy` = 0 at d+1.
  - A new `frame_start` is accepted from d+1 onward.
- `fifo_count`, `fifo_full`, `wr_overflow` update the cycle after the causing `wr_en` or pop.
- The `frame_start` sample of `fifo_count` uses the registered value, excluding any same-cycle write.

## Test plan
- Reset: assert `rst` for 2 cycles mid-activity → every output at its reset value the cycle after; subsequent `tx_done` pulses produce no `send_en`.
- 3-byte frame: write 01,02,03, pulse `frame_start`, model `tx_done` 20 cycles after each `send_en` → bytes AA,03,01,02,03,09 on six `send_en` strobes, each 21 cycles apart; `frame_done` 1 cycle after the 6th `tx_done`; `fifo_count` = 0.
- Empty frame: `frame_start` with FIFO empty → AA,00,00; `frame_done` pulses once.
- Full FIFO: write 17×FF → `fifo_full` = 1, one `wr_overflow` pulse; frame is AA,10, 16×FF, CSUM 00 (wrap check).
- Concurrency: during a 2-byte frame write 3 more bytes and pulse `frame_start` again → current frame LEN = 02 and unaffected; second pulse ignored; `fifo_count` = 3 after `frame_done`.
- Reset mid-payload: assert `rst` after the 2nd payload `send_en` → no further `send_en`; `fifo_count` = 0; a fresh frame afterwards is correct.
